mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS core ALU datapath: fetches each instruction, reads rs/rt

---
 rtl/mips_ctrl_pkg.sv | 45 ++++
 rtl/mips_multicycle_ctrl_decode.sv | 45 ++++
 rtl/mips_multicycle_ctrl.sv | 138 +++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS ALU sequencer: state codes, opcode/funct values, field slices.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // Sequencer states
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    // Opcodes the ALU datapath can execute
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;

    // R-type function codes the ALU datapath can execute
    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_SRA  = 6'd3;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLTU = 6'd43;

    // Instruction field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;

endpackage

// File: rtl/mips_multicycle_ctrl_decode.sv
// Instruction classifier: word -> legal flag, destination register, register-write enable.
// Latency: combinational.
// Backpressure: none.
module mips_instr_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        legal_o,
    output logic [4:0]  dest_reg_o,
    output logic        writes_reg_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = instr_i[OPC_HI:OPC_LO];
    assign funct  = instr_i[FN_HI:FN_LO];
    // rs and shamt only matter to the ALU, not to classification
    assign unused_fields = ^{instr_i[RS_HI:RS_LO], instr_i[10:6]};

    // R-type writes rd, immediate forms write rt; legality is a fixed whitelist
    always_comb begin
        legal_o    = 1'b0;
        dest_reg_o = instr_i[RT_HI:RT_LO];
        if (opcode == OP_RTYPE) begin
            dest_reg_o = instr_i[RD_HI:RD_LO];
            case (funct)
                FN_SLL, FN_SRL, FN_SRA, FN_ADD,
                FN_SUB, FN_AND, FN_OR, FN_SLTU: legal_o = 1'b1;
                default:                        legal_o = 1'b0;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU, OP_SLTI,
                OP_ANDI, OP_ORI, OP_LUI:        legal_o = 1'b1;
                default:                        legal_o = 1'b0;
            endcase
        end
    end

    // Writes to $0 are dropped so the zero register stays zero
    assign writes_reg_o = legal_o && (dest_reg_o != 5'd0);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle fetch/read/execute/writeback sequencer around a combinational ALU; optional INSTR_COUNT_EN adds retired_cnt.
// Latency: 4 cycles per instruction with zero-wait fetch, plus one DONE cycle per program.
// Backpressure: FETCH holds imem_req/imem_addr until imem_ack; start is ignored while busy.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] prog_len,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [31:0]     rf_rdata1,
    input  logic [31:0]     rf_rdata2,
    output logic [31:0]     alu_instr,
    output logic [31:0]     alu_rs,
    output logic [31:0]     alu_rt,
    input  logic [31:0]     alu_result,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [31:0]     rf_wdata,
    output logic            busy,
    output logic            done,
    output logic            illegal
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0]     retired_cnt
`endif
);

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, len_q, pc_inc;
    logic [31:0]     instr_q, rs_q, rt_q, result_q;
    logic            illegal_q;
    logic            start_acc;
    logic            dec_legal, dec_writes;
    logic [4:0]      dec_dest;

    assign start_acc = (state_q == ST_IDLE) && start;
    // prog_len tops out at 2^PC_W-1, so the wrapped increment never aliases below it
    assign pc_inc    = pc_q + PC_W'(1);

    mips_instr_decode u_decode (
        .instr_i      (instr_q),
        .legal_o      (dec_legal),
        .dest_reg_o   (dec_dest),
        .writes_reg_o (dec_writes)
    );

    // Next-state selection for the sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = (prog_len == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH:     if (imem_ack) state_d = ST_DECODE;
            ST_DECODE:    state_d = ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = (pc_inc < len_q) ? ST_FETCH : ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Control state: FSM, program counter, captured program length, sticky illegal flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            len_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                pc_q      <= '0;
                len_q     <= prog_len;
                illegal_q <= 1'b0;
            end else if (state_q == ST_WRITEBACK) begin
                pc_q <= pc_inc;
                if (!dec_legal) illegal_q <= 1'b1;
            end
        end
    end

    // Datapath latches: instruction on fetch ack, operands in DECODE, result in EXECUTE
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q  <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            result_q <= '0;
        end else begin
            if ((state_q == ST_FETCH) && imem_ack) instr_q <= imem_rdata;
            if (state_q == ST_DECODE) begin
                rs_q <= rf_rdata1;
                rt_q <= rf_rdata2;
            end
            if (state_q == ST_EXECUTE) result_q <= alu_result;
        end
    end

`ifdef INSTR_COUNT_EN
    logic [15:0] retired_q;

    // Retired-instruction counter, saturating, restarted by each accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else if (start_acc) begin
            retired_q <= '0;
        end else if ((state_q == ST_WRITEBACK) && (retired_q != 16'hFFFF)) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign retired_cnt = retired_q;
`endif

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign rf_raddr1 = instr_q[RS_HI:RS_LO];
    assign rf_raddr2 = instr_q[RT_HI:RT_LO];
    assign alu_instr = instr_q;
    assign alu_rs    = rs_q;
    assign alu_rt    = rt_q;
    assign rf_we     = (state_q == ST_WRITEBACK) && dec_writes;
    assign rf_waddr  = dec_dest;
    assign rf_wdata  = result_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: table vectors, corner-case sequences, random programs vs reference model.
// Latency: n/a.
// Backpressure: imem model acknowledges after a programmable number of wait cycles.
module tb_mips_multicycle_ctrl;

    localparam int PC_W = 8;
    localparam int LFN[8] = '{0, 2, 3, 32, 34, 36, 37, 43};
    localparam int LOP[6] = '{8, 9, 10, 12, 13, 15};

    logic            clk = 1'b0;
    logic            reset, start;
    logic [PC_W-1:0] prog_len;
    logic            imem_req, imem_ack;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [4:0]      rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0]     rf_rdata1, rf_rdata2, alu_instr, alu_rs, alu_rt, alu_result, rf_wdata;
    logic            rf_we, busy, done, illegal;
`ifdef INSTR_COUNT_EN
    logic [15:0]     retired_cnt;
    logic [15:0]     ret_at_done;
`endif

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_instr(alu_instr), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_result(alu_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .done(done), .illegal(illegal)
`ifdef INSTR_COUNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    // ---------------- environment: instruction memory, register file, ALU ----------------
    logic [31:0] imem_mem [0:255];
    logic [31:0] rf_mem   [0:31];
    int          ack_dly;
    int          req_cnt = 0;
    int          cyc = 0;
    logic        rf_init, clr_mon;

    function automatic logic [31:0] init_val(int i);
        return (i == 9) ? 32'd3 : (i == 10) ? 32'd4 : 32'(i);
    endfunction

    // Reference ALU behaviour (MIPS semantics for the supported subset)
    function automatic logic [31:0] alu_fn(logic [31:0] w, logic [31:0] a, logic [31:0] b);
        logic [31:0] imm_s, imm_z;
        imm_s = {{16{w[15]}}, w[15:0]};
        imm_z = {16'h0, w[15:0]};
        if (w[31:26] == 6'd0) begin
            case (w[5:0])
                6'd0:    return b << w[10:6];
                6'd2:    return b >> w[10:6];
                6'd3:    return 32'($signed(b) >>> w[10:6]);
                6'd32:   return a + b;
                6'd34:   return a - b;
                6'd36:   return a & b;
                6'd37:   return a | b;
                6'd43:   return (a < b) ? 32'd1 : 32'd0;
                default: return 32'hDEADBEEF;
            endcase
        end
        case (w[31:26])
            6'd8, 6'd9: return a + imm_s;
            6'd10:      return ($signed(a) < $signed(imm_s)) ? 32'd1 : 32'd0;
            6'd12:      return a & imm_z;
            6'd13:      return a | imm_z;
            6'd15:      return {w[15:0], 16'h0};
            default:    return 32'hBAD0BAD0;
        endcase
    endfunction

    assign imem_rdata = imem_mem[imem_addr];
    assign imem_ack   = imem_req && (req_cnt == ack_dly);
    assign rf_rdata1  = rf_mem[rf_raddr1];
    assign rf_rdata2  = rf_mem[rf_raddr2];
    assign alu_result = alu_fn(alu_instr, alu_rs, alu_rt);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_req && !imem_ack) req_cnt <= req_cnt + 1;
        else                       req_cnt <= 0;
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    // ---------------- monitor ----------------
    typedef struct { logic [4:0] a; logic [31:0] d; int c; } wr_t;
    wr_t wq[$];
    wr_t exp_q[$];
    int  done_cnt, done_cyc;
    bit  overlap;

    always @(negedge clk) begin
        if (clr_mon) begin
            wq.delete();
            done_cnt = 0;
            done_cyc = -1;
            overlap  = 1'b0;
        end else begin
            if (rf_we) wq.push_back('{rf_waddr, rf_wdata, cyc});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
`ifdef INSTR_COUNT_EN
                ret_at_done = retired_cnt;
`endif
            end
            if (done && rf_we) overlap = 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    int   nvec = 0;
    int   nmis = 0;
    int   run_n, run_d, run_t0;
    bit   exp_ill;
    logic busy_after;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic outs_or();
        logic r;
        r = |{imem_req, imem_addr, rf_raddr1, rf_raddr2, alu_instr, alu_rs, alu_rt,
              rf_we, rf_waddr, rf_wdata, busy, done, illegal};
`ifdef INSTR_COUNT_EN
        r = r | (|retired_cnt);
`endif
        return r;
    endfunction

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic prep_and_start(input int n, input int d);
        ack_dly  = d;
        prog_len = PC_W'(n);
        run_n    = n;
        run_d    = d;
        @(posedge clk); #1;
        rf_init = 1'b1;
        clr_mon = 1'b1;
        @(posedge clk); #1;
        rf_init = 1'b0;
        clr_mon = 1'b0;
        start   = 1'b1;
        run_t0  = cyc;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        int budget;
        k = 0;
        budget = run_n * (4 + run_d) + 40;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        busy_after = busy;
        repeat (3) @(posedge clk);
    endtask

    // Program-level reference: legality whitelist, destination choice, architectural register state
    function automatic bit m_legal(logic [31:0] w);
        int op, fn;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        if (op == 0) return fn inside {0, 2, 3, 32, 34, 36, 37, 43};
        return op inside {8, 9, 10, 12, 13, 15};
    endfunction

    task automatic model_prog();
        logic [31:0] mrf [32];
        logic [31:0] w, val;
        int dst;
        exp_q.delete();
        exp_ill = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = init_val(i);
        for (int j = 0; j < run_n; j++) begin
            w   = imem_mem[j];
            dst = (w[31:26] == 6'd0) ? int'(w[15:11]) : int'(w[20:16]);
            if (!m_legal(w)) begin
                exp_ill = 1'b1;
            end else if (dst != 0) begin
                val = alu_fn(w, mrf[w[25:21]], mrf[w[20:16]]);
                mrf[dst] = val;
                exp_q.push_back('{5'(dst), val, run_t0 + (j + 1) * (4 + run_d)});
            end
        end
    endtask

    task automatic check_run();
        int m;
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_cyc, run_t0 + run_n * (4 + run_d) + 1);
        chk("busy_after_done", busy_after, 0);
        chk("write_count", wq.size(), exp_q.size());
        m = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk("waddr", wq[i].a, exp_q[i].a);
            chk("wdata", wq[i].d, exp_q[i].d);
            chk("wcycle", wq[i].c, exp_q[i].c);
        end
        chk("illegal_end", illegal, exp_ill);
        chk("done_we_overlap", overlap, 0);
`ifdef INSTR_COUNT_EN
        chk("retired_at_done", ret_at_done, run_n);
`endif
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4) begin
            w[31:26] = 6'd0;
            w[5:0]   = 6'(LFN[$urandom_range(0, 7)]);
        end else if (k < 8) begin
            w[31:26] = 6'(LOP[$urandom_range(0, 5)]);
        end else if (k == 8) begin
            w[31:26] = 6'd0;
            w[5:0]   = 6'd12;
        end else begin
            w[31:26] = 6'd35;
        end
        if ($urandom_range(0, 7) == 0) begin
            w[20:16] = 5'd0;
            w[15:11] = 5'd0;
        end
        return w;
    endfunction

    // ---------------- test ----------------
    typedef struct {
        logic [31:0] word;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ill;
    } vec_t;
    vec_t tbl[12];

    initial begin
        tbl[0]  = '{32'h20080005, 1'b1, 5'd8,  32'd5,          1'b0}; // addi $8,$0,5
        tbl[1]  = '{32'h012A4020, 1'b1, 5'd8,  32'd7,          1'b0}; // add $8,$9,$10
        tbl[2]  = '{32'h20000001, 1'b0, 5'd0,  32'd0,          1'b0}; // addi $0 -> dropped
        tbl[3]  = '{32'h8C080000, 1'b0, 5'd0,  32'd0,          1'b1}; // lw -> illegal
        tbl[4]  = '{32'h01095022, 1'b1, 5'd10, 32'd5,          1'b0}; // sub $10,$8,$9
        tbl[5]  = '{32'h3C0BABCD, 1'b1, 5'd11, 32'hABCD0000,   1'b0}; // lui $11
        tbl[6]  = '{32'h0000000C, 1'b0, 5'd0,  32'd0,          1'b1}; // syscall -> illegal
        tbl[7]  = '{32'h00000000, 1'b0, 5'd0,  32'd0,          1'b0}; // sll $0 nop
        tbl[8]  = '{32'h354C00F0, 1'b1, 5'd12, 32'h000000F4,   1'b0}; // ori $12,$10,0xF0
        tbl[9]  = '{32'h11000000, 1'b0, 5'd0,  32'd0,          1'b1}; // beq -> illegal
        tbl[10] = '{32'h290D0009, 1'b1, 5'd13, 32'd1,          1'b0}; // slti $13,$8,9
        tbl[11] = '{32'h000A7043, 1'b1, 5'd14, 32'd2,          1'b0}; // sra $14,$10,1

        reset = 1'b1; start = 1'b0; prog_len = '0; ack_dly = 0;
        rf_init = 1'b0; clr_mon = 1'b1;
        for (int i = 0; i < 256; i++) imem_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", outs_or(), 0);
        reset = 1'b0;
        clr_mon = 1'b0;

        // Single-instruction table vectors
        for (int i = 0; i < 12; i++) begin
            imem_mem[0] = tbl[i].word;
            prep_and_start(1, 0);
            wait_done();
            exp_q.delete();
            if (tbl[i].we) exp_q.push_back('{tbl[i].waddr, tbl[i].wdata, run_t0 + 4});
            exp_ill = tbl[i].ill;
            check_run();
        end

        // Operand routing for add $8,$9,$10 observed in EXECUTE
        imem_mem[0] = 32'h012A4020;
        prep_and_start(1, 0);
        goto_cyc(run_t0 + 3);
        chk("rf_raddr1", rf_raddr1, 9);
        chk("rf_raddr2", rf_raddr2, 10);
        chk("alu_instr", alu_instr, 32'h012A4020);
        chk("alu_rs", alu_rs, 3);
        chk("alu_rt", alu_rt, 4);
        wait_done(); model_prog(); check_run();

        // Illegal first word, legal second; next start clears illegal
        imem_mem[0] = 32'h8C080000;
        imem_mem[1] = 32'h20090002;
        prep_and_start(2, 0);
        goto_cyc(run_t0 + 5);
        chk("illegal_after_first", illegal, 1);
        wait_done(); model_prog(); check_run();
        imem_mem[0] = 32'h20080005;
        prep_and_start(1, 0);
        goto_cyc(run_t0 + 1);
        chk("illegal_cleared_on_start", illegal, 0);
`ifdef INSTR_COUNT_EN
        chk("retired_cleared_on_start", retired_cnt, 0);
`endif
        wait_done(); model_prog(); check_run();

        // Slow fetch: request and address held through wait states
        imem_mem[0] = 32'h20080005;
        imem_mem[1] = 32'h21090001;
        prep_and_start(2, 3);
        for (int c = 1; c <= 11; c++) begin
            goto_cyc(run_t0 + c);
            if (c <= 4) begin
                chk("fetch0_req", imem_req, 1);
                chk("fetch0_addr", imem_addr, 0);
            end else if (c >= 8) begin
                chk("fetch1_req", imem_req, 1);
                chk("fetch1_addr", imem_addr, 1);
            end else if (c == 5) begin
                chk("req_drop_after_ack", imem_req, 0);
            end
        end
        wait_done(); model_prog(); check_run();

        // Reset during EXECUTE aborts without a write
        imem_mem[0] = 32'h20080005;
        prep_and_start(1, 0);
        goto_cyc(run_t0 + 3);
        reset = 1'b1;
        goto_cyc(run_t0 + 4);
        chk("abort_outputs_zero", outs_or(), 0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("abort_no_write", wq.size(), 0);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", busy, 0);

        // Empty program goes straight to DONE
        prep_and_start(0, 0);
        wait_done(); model_prog(); check_run();

        // Start pulse while busy is ignored
        imem_mem[0] = 32'h20080005;
        imem_mem[1] = 32'h21090001;
        prep_and_start(2, 1);
        goto_cyc(run_t0 + 3);
        start = 1'b1;
        prog_len = 8'd5;
        goto_cyc(run_t0 + 4);
        start = 1'b0;
        wait_done(); model_prog(); check_run();

        // Largest program: PC runs to 254 and stops at prog_len 255
        for (int j = 0; j < 255; j++) imem_mem[j] = {6'd9, 5'd0, 5'(j % 31 + 1), 16'(j)};
        prep_and_start(255, 0);
        wait_done(); model_prog(); check_run();

        // Random programs against the reference model
        for (int r = 0; r < 25; r++) begin
            int n, d;
            n = $urandom_range(1, 10);
            d = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) imem_mem[j] = rand_word();
            prep_and_start(n, d);
            wait_done(); model_prog(); check_run();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
